// File: rtl/archlearn_pkg.sv
// Shared opcodes, status bit positions and scheduler state encoding
// for the archlearn SPI command path.
package archlearn_pkg;

    localparam logic [7:0] OP_NOP      = 8'h00;
    localparam logic [3:0] OP_START_HI = 4'h3;
    localparam logic [7:0] OP_CLEAR    = 8'hC0;
    localparam logic [7:0] OP_STATUS   = 8'hFF;

    localparam int ST_BUSY = 7;
    localparam int ST_CONV = 6;
    localparam int ST_OVF  = 5;
    localparam int ST_TMO  = 4;
    localparam int ST_ILL  = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } sched_state_e;

    function automatic logic [7:0] pack_status(
        input logic       busy,
        input logic       conv,
        input logic       ovf,
        input logic       tmo,
        input logic       ill,
        input logic [2:0] cnt
    );
        logic [7:0] st;
        st          = 8'h00;
        st[ST_BUSY] = busy;
        st[ST_CONV] = conv;
        st[ST_OVF]  = ovf;
        st[ST_TMO]  = tmo;
        st[ST_ILL]  = ill;
        st[2:0]     = cnt;
        return st;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO of queued layer indices.
// Ports: push_i/data_i write, pop_i reads data_o (head), full/empty/count.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count_o = wptr_q - rptr_q;
    assign data_o  = mem_q[rptr_q[AW-1:0]];

    // A push into a full FIFO is accepted when the head leaves this cycle;
    // the write lands in the slot being vacated.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/spi_cmd_scheduler.sv
// Decodes SPI command bytes, queues layer starts and sequences the conv engine.
// Ports: rx_* byte in, tx_* status out, eng_* engine handshake, conv_done/status_led.
module spi_cmd_scheduler
    import archlearn_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int LAYER_W     = 4,
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int CNT_W       = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    input  logic               frame_active,
    output logic [7:0]         tx_data,
    output logic               tx_load,
    output logic               eng_start,
    output logic [LAYER_W-1:0] eng_layer,
    input  logic               eng_done,
    output logic               conv_done,
    output logic [7:0]         status_led
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    sched_state_e       state_q;
    logic               eng_start_q;
    logic [LAYER_W-1:0] eng_layer_q;
    logic               busy_q;
    logic               conv_done_q;
    logic [CNT_W-1:0]   cnt_q;

    logic ovf_q, ovf_d;
    logic tmo_q, tmo_d;
    logic ill_q, ill_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_load_q, tx_load_d;

    logic cmd_start, cmd_clear, cmd_status, cmd_illegal;
    logic byte_ok;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [LAYER_W-1:0] fifo_head;
    logic [CW-1:0]      fifo_count;
    logic [2:0]         cnt_sat;

    logic       tmo_hit;
    logic [7:0] status_live;

    assign byte_ok = rx_valid && frame_active;

    always_comb begin
        cmd_start   = 1'b0;
        cmd_clear   = 1'b0;
        cmd_status  = 1'b0;
        cmd_illegal = 1'b0;
        if (byte_ok) begin
            unique case (1'b1)
                (rx_data == OP_NOP): begin
                end
                (rx_data[7:4] == OP_START_HI): cmd_start  = 1'b1;
                (rx_data == OP_CLEAR):         cmd_clear  = 1'b1;
                (rx_data == OP_STATUS):        cmd_status = 1'b1;
                default:                       cmd_illegal = 1'b1;
            endcase
        end
    end

    assign fifo_pop  = (state_q == S_IDLE) && !fifo_empty;
    assign fifo_push = cmd_start;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (LAYER_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (fifo_push),
        .data_i  (rx_data[LAYER_W-1:0]),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    generate
        if (CW > 3) begin : g_sat
            assign cnt_sat = (|fifo_count[CW-1:3]) ? 3'd7 : fifo_count[2:0];
        end else begin : g_nosat
            assign cnt_sat = 3'(fifo_count);
        end
    endgenerate

    // The counter also runs during ISSUE, so the flag appears
    // TIMEOUT_CYC cycles after the eng_start cycle.
    assign tmo_hit = (state_q == S_WAIT) && !eng_done &&
                     (cnt_q >= CNT_W'(TIMEOUT_CYC - 1));

    assign status_live = pack_status(busy_q, conv_done_q, ovf_q,
                                     tmo_q, ill_q, cnt_sat);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            eng_start_q <= 1'b0;
            eng_layer_q <= '0;
            busy_q      <= 1'b0;
            conv_done_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            eng_start_q <= 1'b0;
            if (cmd_clear) conv_done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        eng_layer_q <= fifo_head;
                        eng_start_q <= 1'b1;
                        conv_done_q <= 1'b0;
                        busy_q      <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= cnt_q + CNT_W'(1);
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (eng_done) begin
                        conv_done_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_DONE;
                    end else if (tmo_hit) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // New events win over a same-cycle STATUS/CLEAR so none is lost.
    always_comb begin
        ovf_d     = ovf_q;
        tmo_d     = tmo_q;
        ill_d     = ill_q;
        tx_load_d = cmd_status;
        tx_data_d = tx_data_q;
        if (cmd_status) tx_data_d = status_live;
        if (cmd_status || cmd_clear) begin
            ovf_d = 1'b0;
            tmo_d = 1'b0;
            ill_d = 1'b0;
        end
        if (cmd_start && fifo_full && !fifo_pop) ovf_d = 1'b1;
        if (tmo_hit)                             tmo_d = 1'b1;
        if (cmd_illegal)                         ill_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q     <= 1'b0;
            tmo_q     <= 1'b0;
            ill_q     <= 1'b0;
            tx_data_q <= 8'h00;
            tx_load_q <= 1'b0;
        end else begin
            ovf_q     <= ovf_d;
            tmo_q     <= tmo_d;
            ill_q     <= ill_d;
            tx_data_q <= tx_data_d;
            tx_load_q <= tx_load_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_load    = tx_load_q;
    assign eng_start  = eng_start_q;
    assign eng_layer  = eng_layer_q;
    assign conv_done  = conv_done_q;
    assign status_led = status_live;

endmodule

// File: tb/tb_spi_cmd_scheduler.sv
// Directed bench for spi_cmd_scheduler with a short timeout.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_spi_cmd_scheduler;

    logic       clk;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       frame_active;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       eng_start;
    logic [3:0] eng_layer;
    logic       eng_done;
    logic       conv_done;
    logic [7:0] status_led;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc;
    logic found;

    spi_cmd_scheduler #(
        .FIFO_DEPTH  (4),
        .LAYER_W     (4),
        .TIMEOUT_CYC (16),
        .CNT_W       (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .frame_active (frame_active),
        .tx_data      (tx_data),
        .tx_load      (tx_load),
        .eng_start    (eng_start),
        .eng_layer    (eng_layer),
        .eng_done     (eng_done),
        .conv_done    (conv_done),
        .status_led   (status_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        step();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic done_pulse();
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
    endtask

    task automatic wait_start(input int limit, output logic f,
                              output int n);
        f = 1'b0;
        n = 0;
        for (int i = 0; i < limit; i++) begin
            if (eng_start) begin
                f = 1'b1;
                break;
            end
            step();
            n++;
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_tx_data"},   32'(tx_data),    32'h00);
        chk({pfx, "_tx_load"},   32'(tx_load),    32'h0);
        chk({pfx, "_eng_start"}, 32'(eng_start),  32'h0);
        chk({pfx, "_eng_layer"}, 32'(eng_layer),  32'h0);
        chk({pfx, "_conv_done"}, 32'(conv_done),  32'h0);
        chk({pfx, "_status"},    32'(status_led), 32'h00);
    endtask

    initial begin
        reset        = 1'b0;
        rx_valid     = 1'b0;
        rx_data      = 8'h00;
        frame_active = 1'b0;
        eng_done     = 1'b0;
        repeat (3) step();
        chk_reset("rst0");
        reset = 1'b1;
        step();
        frame_active = 1'b1;

        // single start: push at t, eng_start at t+2
        send(8'h30);
        chk("lat_t1_start", 32'(eng_start), 32'h0);
        step();
        chk("lat_t2_start", 32'(eng_start), 32'h1);
        chk("lat_t2_layer", 32'(eng_layer), 32'h0);
        chk("busy_status",  32'(status_led), 32'h80);
        step();
        chk("start_1cyc",   32'(eng_start), 32'h0);
        send(8'hFF);
        chk("st1_load",     32'(tx_load), 32'h1);
        chk("st1_data",     32'(tx_data), 32'h80);
        step();
        chk("st1_load_off", 32'(tx_load), 32'h0);
        done_pulse();
        chk("done_conv",    32'(conv_done), 32'h1);
        chk("done_status",  32'(status_led), 32'h40);
        send(8'hFF);
        chk("st2_data",     32'(tx_data), 32'h40);
        chk("st2_conv_kept", 32'(conv_done), 32'h1);

        // overflow: layer 0 busy, then 1..5 queued into depth 4
        send(8'h30);
        step();
        chk("ovf_l0_start", 32'(eng_start), 32'h1);
        chk("ovf_conv_clr", 32'(conv_done), 32'h0);
        send(8'h31);
        send(8'h32);
        send(8'h33);
        send(8'h34);
        send(8'h35);
        chk("ovf_live",     32'(status_led), 32'hA4);
        send(8'hFF);
        chk("ovf_tx",       32'(tx_data), 32'hA4);
        chk("ovf_cleared",  32'(status_led), 32'h84);
        done_pulse();
        wait_start(40, found, cyc);
        chk("l1_found",     32'(found), 32'h1);
        chk("l1_gap",       32'(cyc), 32'd2);
        chk("l1_layer",     32'(eng_layer), 32'h1);
        // done during ISSUE must be ignored
        done_pulse();
        chk("early_done_ign", 32'(conv_done), 32'h0);
        chk("early_busy",   32'(status_led[7]), 32'h1);
        done_pulse();
        for (int l = 2; l <= 4; l++) begin
            wait_start(40, found, cyc);
            chk("lN_found", 32'(found), 32'h1);
            chk("lN_layer", 32'(eng_layer), 32'(l));
            step();
            done_pulse();
        end
        wait_start(30, found, cyc);
        chk("l5_never",     32'(found), 32'h0);
        chk("layer_hold",   32'(eng_layer), 32'h4);
        chk("final_conv",   32'(conv_done), 32'h1);

        // illegal opcode
        send(8'h77);
        send(8'hFF);
        chk("ill_tx1",      32'(tx_data), 32'h48);
        send(8'hFF);
        chk("ill_tx2",      32'(tx_data), 32'h40);
        send(8'hC0);
        chk("clear_conv",   32'(conv_done), 32'h0);
        chk("clear_status", 32'(status_led), 32'h00);

        // timeout: layer 6 never completes, layer 7 queued behind it
        send(8'h36);
        send(8'h37);
        chk("tmo_start",    32'(eng_start), 32'h1);
        chk("tmo_layer",    32'(eng_layer), 32'h6);
        repeat (15) step();
        chk("tmo_not_yet",  32'(status_led[4]), 32'h0);
        step();
        chk("tmo_status",   32'(status_led), 32'h11);
        step();
        chk("tmo_next_start", 32'(eng_start), 32'h1);
        chk("tmo_next_layer", 32'(eng_layer), 32'h7);

        // reset mid-job with two queued
        send(8'h38);
        send(8'h39);
        chk("rstj_status",  32'(status_led), 32'h92);
        #2;
        reset = 1'b0;
        #1;
        chk_reset("rst1");
        step();
        step();
        reset = 1'b1;
        step();
        wait_start(30, found, cyc);
        chk("rst_no_start", 32'(found), 32'h0);
        chk("rst_status",   32'(status_led), 32'h00);

        // bytes outside a frame are ignored
        frame_active = 1'b0;
        send(8'h30);
        send(8'h77);
        wait_start(10, found, cyc);
        chk("nofr_no_start", 32'(found), 32'h0);
        chk("nofr_status",  32'(status_led), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_cmd_scheduler.md
Name: spi_cmd_scheduler

Overview:
- Sits between the SPI slave byte receiver and the convolution engine in the archlearn top level.
- Decodes command bytes arriving over SPI and queues layer-start requests in a small FIFO.
- Issues one start to the engine at a time, waits for done or timeout, and drives the status byte returned on MISO.
- Also drives the conv-complete level that the top level exports (convout) and the LED status vector.

Parameters:
- FIFO_DEPTH, 4, number of queued start commands (power of two, 2..16)
- LAYER_W, 4, width of layer index carried in the low nibble of the opcode
- TIMEOUT_CYC, 1_000_000, clk cycles allowed between eng_start and eng_done before timeout
- CNT_W, 20, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC

Ports:
- clk, input, 1, system clock
- reset, input, 1, asynchronous active-low reset
- rx_valid, input, 1, one-cycle pulse: rx_data holds a complete received byte (already clk-synchronous)
- rx_data, input, 8, received command byte
- frame_active, input, 1, nss synchronised, high while nss low
- tx_data, output, 8, byte for SPI slave to shift out on next frame
- tx_load, output, 1, one-cycle pulse: SPI slave latches tx_data
- eng_start, output, 1, one-cycle start pulse to conv engine
- eng_layer, output, LAYER_W, layer index; valid and held from eng_start until done/timeout
- eng_done, input, 1, one-cycle completion pulse from engine
- conv_done, output, 1, level, set on eng_done, cleared by next START issue or by CLEAR
- status_led, output, 8, mirror of the live status byte

Behaviour:
- Reset (reset=0, async): FSM=IDLE, FIFO empty, all flags 0; tx_data=0x00, tx_load=0, eng_start=0, eng_layer=0, conv_done=0, status_led=0x00.
- Opcodes, decoded in the cycle rx_valid=1:
  - 0x00: NOP
  - 0x3N: START layer N (push N to FIFO)
  - 0xC0: CLEAR (clears conv_done and all sticky flags)
  - 0xFF: STATUS
  - any other value: sets sticky illegal.
- Bytes are ignored when frame_active=0.
- Status byte = {busy, conv_done, overflow, timeout, illegal, fifo_count[2:0]}. fifo_count saturates at 7.
- STATUS: the cycle after rx_valid, tx_data=status snapshot and tx_load=1 for one cycle. overflow, timeout and illegal then clear; conv_done does not clear.
- START while FIFO full: the byte is dropped and overflow is set. When push and pop occur in the same cycle with the FIFO full, the push is accepted.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: FIFO non-empty -> pop; eng_layer<=head; go to ISSUE.
  - ISSUE: eng_start=1 for exactly 1 cycle; conv_done<=0; counter<=0; busy=1; go to WAIT.
  - WAIT: eng_done -> DONE. counter==TIMEOUT_CYC-1 -> timeout<=1, go to IDLE (the job is abandoned).
  - DONE: conv_done<=1, busy<=0, go to IDLE (1 cycle).
- Latency: FIFO push at cycle t → eng_start at t+2 if the FSM is IDLE.
- Back-to-back jobs: a gap of ≥2 cycles between eng_done and the next eng_start.
- An eng_done outside WAIT is ignored. A CLEAR during WAIT does not abort the job.
- Reset asserted mid-job drops the FIFO contents and the job; no eng_start is issued after reset releases until a new START arrives.
- eng_layer holds its value after the job completes, until the next pop.

Decomposition:
- Shared package archlearn_pkg holds:
  - opcode constants OP_NOP=8'h00, OP_START_HI=4'h3, OP_CLEAR=8'hC0, OP_STATUS=8'hFF
  - status bit-index constants
  - FSM state encoding (2-bit).
- One sub-module: cmd_fifo (synchronous FIFO with parameters DEPTH and WIDTH=LAYER_W; push, pop, full, empty, count).

Test Plan:
- Reset release, then rx 0x30 → one eng_start 2 cycles after push with eng_layer=0. Then rx 0xFF → tx_load with tx_data=8'b1000_0000 (busy=1, count=0).
- Pulse eng_done → conv_done=1 the following cycle. Then rx 0xFF → tx_data=8'b0100_0000.
- While busy, rx 0x31, 0x32, 0x33, 0x34, 0x35 (FIFO_DEPTH=4) → status reads overflow=1 and count=4. Layers 1, 2, 3, 4 start in order; 5 is never started.
- rx 0x77 → illegal=1. First 0xFF returns bit3=1; a second 0xFF returns bit3=0.
- Start with no eng_done and TIMEOUT_CYC=16 → timeout=1 exactly 16 cycles after eng_start, FSM back to IDLE, next queued job issued.
- Assert reset during WAIT with 2 queued jobs → all outputs return to reset values. No eng_start after release without new bytes.
- Bytes with frame_active=0 (rx 0x30) → no push, no eng_start.
